// File: rtl/tb_stim_pkg.sv
// tb_stim_pkg: shared types and constants for the stimulus sequencer.
//   mode_e        - stimulus pattern selector
//   state_e       - sequencer FSM states (exported on dbg_state)
//   DEF_LFSR_POLY - default Galois feedback taps for the LFSR pattern
package tb_stim_pkg;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_INC   = 2'd1,
        MODE_DEC   = 2'd2,
        MODE_LFSR  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;

endpackage

// File: rtl/tb_sig_misr.sv
// tb_sig_misr: rotate-XOR response compactor.
//   clk      - rising-edge clock
//   rst      - asynchronous active-low reset, clears the signature
//   i_clr    - synchronous clear (start of a run)
//   i_cap    - capture enable: fold i_resp into the signature this edge
//   i_resp   - response word
//   o_sig    - signature register
module tb_sig_misr
    import tb_stim_pkg::*;
#(
    parameter int RESP_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_cap,
    input  logic [RESP_WIDTH-1:0] i_resp,
    output logic [RESP_WIDTH-1:0] o_sig
);

    logic [RESP_WIDTH-1:0] r_sig;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sig <= '0;
        end else if (i_clr) begin
            r_sig <= '0;
        end else if (i_cap) begin
            // rotate left by one, then fold in the new response
            r_sig <= {r_sig[RESP_WIDTH-2:0], r_sig[RESP_WIDTH-1]} ^ i_resp;
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/tb_stim_seq.sv
// tb_stim_seq: stimulus sequencer and response compactor.
//   clk        - rising-edge clock
//   rst        - asynchronous active-low reset
//   start      - one-cycle run request, accepted only in IDLE/DONE
//   mode, seed - pattern and first word, sampled with an accepted start
//   resp       - DUT response, compacted RESP_LAT cycles after each word
//   dut_rst    - active-high DUT reset
//   stim       - stimulus word; stim_valid marks a counted iteration
//   iter_cnt   - words issued in this run
//   busy, done - run in progress / run complete (done held until next start)
//   signature  - rotate-XOR compaction of the captured responses
//   dbg_state  - current FSM state
// Handshake: start is a single-cycle request with no ready; it is acted on
// when the FSM is in IDLE or DONE and silently dropped otherwise (busy=1).
module tb_stim_seq
    import tb_stim_pkg::*;
#(
    parameter int                RESP_WIDTH = 32,
    parameter int                WIDTH      = 16,
    parameter int                NUM_ITER   = 10,
    parameter int                RST_CYCLES = 2,
    parameter int                RESP_LAT   = 1,
    parameter logic [WIDTH-1:0]  LFSR_POLY  = WIDTH'(DEF_LFSR_POLY)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [1:0]                    mode,
    input  logic [WIDTH-1:0]              seed,
    input  logic [RESP_WIDTH-1:0]         resp,
    output logic                          dut_rst,
    output logic [WIDTH-1:0]              stim,
    output logic                          stim_valid,
    output logic [$clog2(NUM_ITER+1)-1:0] iter_cnt,
    output logic                          busy,
    output logic                          done,
    output logic [RESP_WIDTH-1:0]         signature,
    output state_e                        dbg_state
);

    localparam int ITER_W  = $clog2(NUM_ITER + 1);
    localparam int CNT_MAX = (RST_CYCLES > 8) ? RST_CYCLES : 8;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int LAT_D   = (RESP_LAT == 0) ? 1 : RESP_LAT;

    state_e             r_state;
    mode_e              r_mode;
    logic [WIDTH-1:0]   r_seed;
    logic [WIDTH-1:0]   r_stim;
    logic               r_stim_valid;
    logic [ITER_W-1:0]  r_iter;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dut_rst;
    logic               r_busy;
    logic               r_done;
    logic [LAT_D-1:0]   r_vsh;

    logic               w_accept;
    logic               w_cap;
    logic [WIDTH-1:0]   w_next;
    logic [WIDTH-1:0]   w_seed_fix;

    function automatic logic [WIDTH-1:0] next_stim(input mode_e m, input logic [WIDTH-1:0] s);
        case (m)
            MODE_INC:  return s + WIDTH'(1);
            MODE_DEC:  return s - WIDTH'(1);
            MODE_LFSR: return (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
            default:   return s;
        endcase
    endfunction

    assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_next     = next_stim(r_mode, r_stim);
    // an all-zero LFSR state never leaves zero, so force it to 1
    assign w_seed_fix = ((mode == 2'd3) && (seed == '0)) ? WIDTH'(1) : seed;
    // capture marker: stim_valid delayed by RESP_LAT cycles
    assign w_cap      = (RESP_LAT == 0) ? r_stim_valid : r_vsh[LAT_D-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vsh <= '0;
        end else begin
            r_vsh[0] <= r_stim_valid;
            for (int i = 1; i < LAT_D; i++) begin
                r_vsh[i] <= r_vsh[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_mode       <= MODE_CONST;
            r_seed       <= '0;
            r_stim       <= '0;
            r_stim_valid <= 1'b0;
            r_iter       <= '0;
            r_cnt        <= '0;
            r_dut_rst    <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_mode    <= mode_e'(mode);
                        r_seed    <= w_seed_fix;
                        r_iter    <= '0;
                        r_cnt     <= '0;
                        r_dut_rst <= 1'b1;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_state   <= ST_RESET;
                    end else if (r_state == ST_DONE) begin
                        // completion flags follow one edge after entering DONE
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                ST_RESET: begin
                    if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        // leave reset and issue the first word on the same edge
                        r_dut_rst    <= 1'b0;
                        r_stim       <= r_seed;
                        r_stim_valid <= 1'b1;
                        r_iter       <= ITER_W'(1);
                        r_cnt        <= '0;
                        r_state      <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (r_iter == ITER_W'(NUM_ITER)) begin
                        r_stim_valid <= 1'b0;
                        r_state      <= (RESP_LAT == 0) ? ST_DONE : ST_DRAIN;
                    end else begin
                        r_stim <= w_next;
                        r_iter <= r_iter + ITER_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == CNT_W'(RESP_LAT - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    tb_sig_misr #(
        .RESP_WIDTH (RESP_WIDTH)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_accept),
        .i_cap  (w_cap),
        .i_resp (resp),
        .o_sig  (signature)
    );

    assign dut_rst    = r_dut_rst;
    assign stim       = r_stim;
    assign stim_valid = r_stim_valid;
    assign iter_cnt   = r_iter;
    assign busy       = r_busy;
    assign done       = r_done;
    assign dbg_state  = r_state;

endmodule
